// File: rtl/dcache_state_array.sv
// Per-set, per-way D-cache state store with partitioned round-robin victim selection and a clear engine.
// Read latency is one cycle (rd_en at edge N gives rd_valid/rd_state/victim_way at edge N+1); writes land at the edge.
// While flush_busy is high, rd_en and wr_en are dropped without being held or queued; the controller must retry them.
module dcache_state_array #(
  parameter int WAYS = 4,
  parameter int DW   = 2,
  parameter int AW   = 6,
  parameter int WW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_req,
  output logic                 flush_busy,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_index,
  input  logic                 rd_part,
  output logic                 rd_valid,
  output logic [WAYS*DW-1:0]   rd_state,
  output logic [WW-1:0]        victim_way,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_index,
  input  logic [WW-1:0]        wr_way,
  input  logic [DW-1:0]        wr_din
);

  localparam int NUM  = 1 << AW;
  localparam int HALF = WAYS / 2;
  localparam int RW   = WAYS * DW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  clr_state_t    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  // State bits per set; contents are only ever defined by the clear engine or writes.
  logic [RW-1:0] mem [NUM];
  // Round-robin pointers hold an absolute way number inside their partition.
  logic [WW-1:0] rr_ptr [NUM][2];

  logic          idle;
  logic          rd_go;
  logic          wr_go;
  logic          same_idx;
  logic [RW-1:0] row_pw;
  logic [WW-1:0] ptr_pw;
  logic [WW-1:0] victim_d;
  logic [DW-1:0] way_pw [WAYS];

  // First way of a partition: 0 for the lower half, WAYS/2 for the upper half.
  function automatic logic [WW-1:0] part_base(input logic part);
    return part ? WW'(HALF) : '0;
  endfunction

  // Advance a pointer by one, wrapping back to the base of its own partition.
  function automatic logic [WW-1:0] ptr_next(input logic [WW-1:0] p);
    logic [WW:0] nxt;
    logic [WW:0] lim;
    logic [WW:0] base;
    base = {1'b0, part_base(p[WW-1])};
    nxt  = {1'b0, p} + (WW+1)'(1);
    lim  = base + (WW+1)'(HALF);
    if (nxt == lim) begin
      nxt = base;
    end
    return nxt[WW-1:0];
  endfunction

  assign idle       = (state_q == IDLE);
  assign flush_busy = (state_q == CLEAR);
  assign rd_go      = idle && rd_en;
  assign wr_go      = idle && wr_en;
  assign same_idx   = wr_go && (wr_index == rd_index);

  // Clear-engine state and set counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Clear-engine sequencing: walk sets 0..NUM-1 once, then return to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NUM - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Read-side view of the addressed set with a same-cycle write merged in (write-first).
  always_comb begin
    row_pw = mem[rd_index];
    ptr_pw = rr_ptr[rd_index][rd_part];
    if (same_idx) begin
      row_pw[wr_way*DW +: DW] = wr_din;
      if (wr_din[0] && (wr_way[WW-1] == rd_part) && (wr_way == ptr_pw)) begin
        ptr_pw = ptr_next(ptr_pw);
      end
    end
  end

  // Split the merged row into per-way fields for the victim search.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_pw[w] = row_pw[w*DW +: DW];
    end
  end

  // Victim: lowest invalid way of the partition, else that partition's pointer.
  always_comb begin
    logic found;
    int   base;
    victim_d = ptr_pw;
    found    = 1'b0;
    base     = rd_part ? HALF : 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && (w >= base) && (w < base + HALF) && !way_pw[w][0]) begin
        victim_d = WW'(w);
        found    = 1'b1;
      end
    end
  end

  // State storage: the clear engine owns the array while busy, otherwise the write port.
  always_ff @(posedge clk) begin
    if (flush_busy) begin
      mem[clr_idx_q] <= '0;
    end else if (rst_n && wr_en) begin
      mem[wr_index][wr_way*DW +: DW] <= wr_din;
    end
  end

  // Pointer storage: reset/clear to partition base; advance when the pointed way is filled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM; s++) begin
        rr_ptr[s][0] <= part_base(1'b0);
        rr_ptr[s][1] <= part_base(1'b1);
      end
    end else if (flush_busy) begin
      rr_ptr[clr_idx_q][0] <= part_base(1'b0);
      rr_ptr[clr_idx_q][1] <= part_base(1'b1);
    end else if (wr_en && wr_din[0] && (wr_way == rr_ptr[wr_index][wr_way[WW-1]])) begin
      rr_ptr[wr_index][wr_way[WW-1]] <= ptr_next(wr_way);
    end
  end

  // Registered read port; rd_state and victim_way hold between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      rd_state   <= '0;
      victim_way <= '0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_state   <= row_pw;
        victim_way <= victim_d;
      end
    end
  end

endmodule

// File: tb/tb_dcache_state_array.sv
// Directed bench for dcache_state_array (WAYS=4, DW=2, AW=6).
// Vector table for read/write/victim behaviour plus hand sequences for clear/flush/reset.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_dcache_state_array;

  logic       clk;
  logic       rst_n;
  logic       flush_req;
  logic       flush_busy;
  logic       rd_en;
  logic [5:0] rd_index;
  logic       rd_part;
  logic       rd_valid;
  logic [7:0] rd_state;
  logic [1:0] victim_way;
  logic       wr_en;
  logic [5:0] wr_index;
  logic [1:0] wr_way;
  logic [1:0] wr_din;

  int errors = 0;
  int checks = 0;

  dcache_state_array #(.WAYS(4), .DW(2), .AW(6), .WW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .rd_en      (rd_en),
    .rd_index   (rd_index),
    .rd_part    (rd_part),
    .rd_valid   (rd_valid),
    .rd_state   (rd_state),
    .victim_way (victim_way),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_way     (wr_way),
    .wr_din     (wr_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       wr;
    logic [5:0] widx;
    logic [1:0] wway;
    logic [1:0] wdin;
    logic       rd;
    logic [5:0] ridx;
    logic       rpart;
    logic       evld;
    logic [7:0] estate;
    logic [1:0] evic;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Count consecutive cycles (including the current one) with flush_busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (flush_busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [5:0] widx, input logic [1:0] wway,
                              input logic [1:0] wdin, input logic rd, input logic [5:0] ridx,
                              input logic rpart, input logic evld, input logic [7:0] est,
                              input logic [1:0] evic);
    vec_t v;
    v.wr = wr; v.widx = widx; v.wway = wway; v.wdin = wdin;
    v.rd = rd; v.ridx = ridx; v.rpart = rpart;
    v.evld = evld; v.estate = est; v.evic = evic;
    return v;
  endfunction

  initial begin
    int n;
    int bad;

    // rd_state encoding: way w at bits [2w+1:2w], bit0 valid, bit1 dirty.
    vecs[0]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd0,  1'b0, 1'b1, 8'h00, 2'd0);
    vecs[1]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd63, 1'b1, 1'b1, 8'h00, 2'd2);
    vecs[2]  = mk(1'b1, 6'd5, 2'd1, 2'b01, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 2'd0);
    vecs[3]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd5,  1'b0, 1'b1, 8'h04, 2'd0);
    vecs[4]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd5,  1'b1, 1'b1, 8'h04, 2'd2);
    // set 9: way1 valid (ptr0 stays 0), way0 valid (ptr0 -> 1)
    vecs[5]  = mk(1'b1, 6'd9, 2'd1, 2'b01, 1'b0, 6'd0,  1'b0, 1'b0, 8'h04, 2'd0);
    vecs[6]  = mk(1'b1, 6'd9, 2'd0, 2'b01, 1'b0, 6'd0,  1'b0, 1'b0, 8'h04, 2'd0);
    vecs[7]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd9,  1'b0, 1'b1, 8'h05, 2'd1);
    // way1 valid again with ptr0=1 -> wraps to 0; write-first victim sees it
    vecs[8]  = mk(1'b1, 6'd9, 2'd1, 2'b01, 1'b1, 6'd9,  1'b0, 1'b1, 8'h05, 2'd0);
    vecs[9]  = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd9,  1'b0, 1'b1, 8'h05, 2'd0);
    // invalidating write does not advance the pointer
    vecs[10] = mk(1'b1, 6'd9, 2'd0, 2'b00, 1'b1, 6'd9,  1'b0, 1'b1, 8'h04, 2'd0);
    // part1 write (ptr1 2->3) leaves part0 alone
    vecs[11] = mk(1'b1, 6'd9, 2'd2, 2'b11, 1'b1, 6'd9,  1'b0, 1'b1, 8'h34, 2'd0);
    vecs[12] = mk(1'b1, 6'd9, 2'd0, 2'b01, 1'b1, 6'd9,  1'b1, 1'b1, 8'h35, 2'd3);
    // way3 valid with ptr1=3 -> wraps to 2, partition full -> victim 2
    vecs[13] = mk(1'b1, 6'd9, 2'd3, 2'b01, 1'b1, 6'd9,  1'b1, 1'b1, 8'h75, 2'd2);
    vecs[14] = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd9,  1'b0, 1'b1, 8'h75, 2'd1);
    // same-cycle write/read to set 3
    vecs[15] = mk(1'b1, 6'd3, 2'd2, 2'b11, 1'b1, 6'd3,  1'b1, 1'b1, 8'h30, 2'd3);
    // write to a different set in the same cycle does not leak into the read
    vecs[16] = mk(1'b1, 6'd4, 2'd0, 2'b01, 1'b1, 6'd3,  1'b1, 1'b1, 8'h30, 2'd3);
    vecs[17] = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b1, 6'd4,  1'b0, 1'b1, 8'h01, 2'd1);
    vecs[18] = mk(1'b0, 6'd0, 2'd0, 2'b00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h01, 2'd0);

    rst_n = 1'b0; flush_req = 1'b0;
    rd_en = 1'b0; rd_index = '0; rd_part = 1'b0;
    wr_en = 1'b0; wr_index = '0; wr_way = '0; wr_din = '0;

    // Reset state and initial clear length
    tick();
    chk("reset.flush_busy", 32'(flush_busy), 32'd1);
    chk("reset.rd_valid",   32'(rd_valid),   32'd0);
    chk("reset.rd_state",   32'(rd_state),   32'h00);
    chk("reset.victim_way", 32'(victim_way), 32'd0);
    rst_n = 1'b1;
    count_busy(n);
    chk("reset.busy_cycles", 32'(n), 32'd64);
    chk("reset.busy_done",  32'(flush_busy), 32'd0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].wr; wr_index = vecs[i].widx; wr_way = vecs[i].wway; wr_din = vecs[i].wdin;
      rd_en = vecs[i].rd; rd_index = vecs[i].ridx; rd_part = vecs[i].rpart;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].evld));
      chk($sformatf("vec%0d.rd_state", i), 32'(rd_state), 32'(vecs[i].estate));
      if (vecs[i].evld) begin
        chk($sformatf("vec%0d.victim", i), 32'(victim_way), 32'(vecs[i].evic));
      end
    end

    // Flush with dirty data everywhere; rd/wr and a second flush_req during busy are dropped
    for (int s = 0; s < 64; s++) begin
      wr_en = 1'b1; wr_index = 6'(s); wr_way = 2'(s % 4); wr_din = 2'b11;
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1; rd_index = 6'd10; rd_part = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("flush.pre_state", 32'(rd_state), 32'h30);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("flush.busy_start", 32'(flush_busy), 32'd1);
    n = 1; bad = 0;
    while (flush_busy === 1'b1 && n < 300) begin
      rd_en = 1'b1; rd_index = 6'(n % 64); rd_part = 1'b0;
      wr_en = 1'b1; wr_index = 6'(n % 64); wr_way = 2'd0; wr_din = 2'b01;
      flush_req = (n == 20);
      tick();
      if (rd_valid !== 1'b0) bad++;
      if (flush_busy === 1'b1) n++;
    end
    rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
    chk("flush.busy_cycles", 32'(n), 32'd64);
    chk("flush.rd_valid_while_busy", 32'(bad), 32'd0);
    bad = 0;
    for (int s = 0; s < 64; s++) begin
      rd_en = 1'b1; rd_index = 6'(s); rd_part = s[0];
      tick();
      if (rd_valid !== 1'b1 || rd_state !== 8'h00 || victim_way !== (s[0] ? 2'd2 : 2'd0)) bad++;
    end
    rd_en = 1'b0;
    chk("flush.sets_not_clear", 32'(bad), 32'd0);
    chk("flush.last_victim", 32'(victim_way), 32'd2);

    // Reset in the middle of a clear restarts the full walk
    wr_en = 1'b1; wr_index = 6'd40; wr_way = 2'd3; wr_din = 2'b11;
    tick();
    wr_en = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("midrst.busy_before", 32'(flush_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.rd_valid", 32'(rd_valid), 32'd0);
    count_busy(n);
    chk("midrst.busy_cycles", 32'(n), 32'd64);
    rd_en = 1'b1; rd_index = 6'd40; rd_part = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("midrst.rd_valid_after", 32'(rd_valid), 32'd1);
    chk("midrst.rd_state", 32'(rd_state), 32'h00);
    chk("midrst.victim", 32'(victim_way), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
